regfile_write_queue: RTL and testbench

- Write-side initiator for the 32x32 register file: buffers write-back requests from the execute/memory stages and drains them, one per cycle, onto the register file write port (RegWrite / WriteRegNo / WriteData).
- Provides two bypass lookup ports so that reads issued before a queued write retires still see the youngest pending value.
- Sits between the pipeline's write-back stage and the register file.

---
 rtl/regfile_write_queue_pkg.sv | 15 +
 rtl/regfile_write_queue_if.sv | 44 ++++
 rtl/regfile_write_queue_bypass.sv | 34 +++
 rtl/regfile_write_queue.sv | 96 +++++++++
 tb/tb_regfile_write_queue.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/regfile_write_queue_pkg.sv
// Shared types and constants for the register file write queue.
package regfile_write_queue_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;

    localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

    // One pending register file write.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] regno;
        logic [DATA_W-1:0]     data;
    } entry_t;

endpackage

// File: rtl/regfile_write_queue_if.sv
// Bundle of the request, register file write and bypass lookup signals.
// The queue sits on the slave side; the pipeline / register file side is master.
interface regfile_write_queue_if
    import regfile_write_queue_pkg::*;
#(
    parameter int PTR_W = 2
);
    // Request side
    logic                  req_valid;
    logic                  req_ready;
    logic [REG_ADDR_W-1:0] req_regno;
    logic [DATA_W-1:0]     req_data;

    // Register file write port
    logic                  hold;
    logic                  reg_write;
    logic [REG_ADDR_W-1:0] write_regno;
    logic [DATA_W-1:0]     write_data;

    // Bypass lookup
    logic [REG_ADDR_W-1:0] look_reg1;
    logic [REG_ADDR_W-1:0] look_reg2;
    logic                  look_hit1;
    logic                  look_hit2;
    logic [DATA_W-1:0]     look_data1;
    logic [DATA_W-1:0]     look_data2;

    // Status
    logic [PTR_W:0]        count;
    logic                  empty;

    modport master (
        output req_valid, req_regno, req_data, hold, look_reg1, look_reg2,
        input  req_ready, reg_write, write_regno, write_data,
               look_hit1, look_hit2, look_data1, look_data2, count, empty
    );

    modport slave (
        input  req_valid, req_regno, req_data, hold, look_reg1, look_reg2,
        output req_ready, reg_write, write_regno, write_data,
               look_hit1, look_hit2, look_data1, look_data2, count, empty
    );

endinterface

// File: rtl/regfile_write_queue_bypass.sv
// Youngest-match search over the occupied queue entries for one lookup port.
module regfile_bypass_match
    import regfile_write_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  entry_t [DEPTH-1:0]    entries,
    input  logic [PTR_W-1:0]      head,
    input  logic [PTR_W:0]        count,
    input  logic [REG_ADDR_W-1:0] look_reg,
    output logic                  hit,
    output logic [DATA_W-1:0]     data
);

    logic [PTR_W-1:0] idx;

    // Walk oldest to youngest so the last match found is the youngest one.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        hit  = 1'b0;
        data = '0;
        idx  = head;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PTR_W'(i);
            if (((PTR_W + 1)'(i) < count) && (look_reg != ZERO_REG) &&
                (entries[idx].regno == look_reg)) begin
                hit  = 1'b1;
                data = entries[idx].data;
            end
        end
    end

endmodule

// File: rtl/regfile_write_queue.sv
// Circular buffer of pending register file writes, drained one per cycle,
// with two combinational bypass lookup ports.
module regfile_write_queue
    import regfile_write_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input logic                 clk,
    input logic                 rst,
    regfile_write_queue_if.slave q
);

    entry_t [DEPTH-1:0] entries;
    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic [PTR_W:0]     count;

    logic accept;
    logic push;
    logic pop;

    // Handshake, register 0 filter and drain strobe.
    always_comb begin
        q.req_ready = (count != (PTR_W + 1)'(DEPTH));
        q.empty     = (count == '0);
        accept      = q.req_valid && q.req_ready;
        push        = accept && (q.req_regno != ZERO_REG);
        q.reg_write = !q.empty && !q.hold;
        pop         = q.reg_write;
    end

    // Head entry onto the write port; forced to zero so stale contents never show.
    always_comb begin
        q.write_regno = '0;
        q.write_data  = '0;
        if (!q.empty) begin
            q.write_regno = entries[head].regno;
            q.write_data  = entries[head].data;
        end
    end

    assign q.count = count;

    // Pointer and occupancy registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage written at the tail.
    // NOTE: the entry array has no reset; occupancy is tracked by count and nothing reads an empty slot.
    always_ff @(posedge clk) begin
        if (push) begin
            entries[tail].regno <= q.req_regno;
            entries[tail].data  <= q.req_data;
        end
    end

    regfile_bypass_match #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_match1 (
        .entries  (entries),
        .head     (head),
        .count    (count),
        .look_reg (q.look_reg1),
        .hit      (q.look_hit1),
        .data     (q.look_data1)
    );

    regfile_bypass_match #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_match2 (
        .entries  (entries),
        .head     (head),
        .count    (count),
        .look_reg (q.look_reg2),
        .hit      (q.look_hit2),
        .data     (q.look_data2)
    );

endmodule

// File: tb/tb_regfile_write_queue.sv
// Directed bench for regfile_write_queue: inputs change and outputs are
// sampled while the clock is low, away from the rising edge.
module tb_regfile_write_queue;

    logic clk = 1'b0;
    logic rst;

    int n_checks = 0;
    int n_errors = 0;

    regfile_write_queue_if #(.PTR_W(2)) bus ();

    regfile_write_queue #(
        .DEPTH (4),
        .PTR_W (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .q   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance through one rising edge and settle in the low phase.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] r, input logic [31:0] d);
        bus.req_valid = v;
        bus.req_regno = r;
        bus.req_data  = d;
        #1;
    endtask

    initial begin
        rst           = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_regno = '0;
        bus.req_data  = '0;
        bus.hold      = 1'b0;
        bus.look_reg1 = 5'd5;
        bus.look_reg2 = 5'd0;
        step();
        step();

        // Reset state
        check("rst_regwrite", 32'(bus.reg_write), 32'd0);
        check("rst_ready",    32'(bus.req_ready), 32'd1);
        check("rst_empty",    32'(bus.empty),     32'd1);
        check("rst_count",    32'(bus.count),     32'd0);
        check("rst_hit1",     32'(bus.look_hit1), 32'd0);
        check("rst_data1",    bus.look_data1,     32'd0);
        check("rst_hit2",     32'(bus.look_hit2), 32'd0);
        check("rst_data2",    bus.look_data2,     32'd0);
        check("rst_wregno",   32'(bus.write_regno), 32'd0);
        check("rst_wdata",    bus.write_data,     32'd0);
        rst = 1'b0;
        #1;

        // Single request, one-cycle latency
        drive(1'b1, 5'd5, 32'hDEADBEEF);
        check("t1_look_before_edge", 32'(bus.look_hit1), 32'd0);
        step();
        drive(1'b0, 5'd0, 32'd0);
        check("t1_regwrite", 32'(bus.reg_write), 32'd1);
        check("t1_wregno",   32'(bus.write_regno), 32'd5);
        check("t1_wdata",    bus.write_data, 32'hDEADBEEF);
        check("t1_count",    32'(bus.count), 32'd1);
        check("t1_hit1",     32'(bus.look_hit1), 32'd1);
        check("t1_data1",    bus.look_data1, 32'hDEADBEEF);
        step();
        check("t1_empty",    32'(bus.empty), 32'd1);
        check("t1_regwrite_off", 32'(bus.reg_write), 32'd0);

        // Fill under hold, reject fifth, then drain in order
        bus.hold = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 5'(i), 32'(i * 16));
            check("t2_ready_fill", 32'(bus.req_ready), 32'd1);
            step();
            check("t2_hold_nowrite", 32'(bus.reg_write), 32'd0);
        end
        check("t2_count_full", 32'(bus.count), 32'd4);
        check("t2_ready_full", 32'(bus.req_ready), 32'd0);
        drive(1'b1, 5'd9, 32'h99);
        step();
        drive(1'b0, 5'd0, 32'd0);
        check("t2_count_after_5th", 32'(bus.count), 32'd4);
        bus.hold = 1'b0;
        #1;
        check("t2_ready_full_popping", 32'(bus.req_ready), 32'd0);
        for (int i = 1; i <= 4; i++) begin
            check("t2_drain_regwrite", 32'(bus.reg_write), 32'd1);
            check("t2_drain_regno", 32'(bus.write_regno), 32'(i));
            check("t2_drain_data",  bus.write_data, 32'(i * 16));
            step();
        end
        check("t2_empty", 32'(bus.empty), 32'd1);

        // Register 0 filter
        bus.look_reg1 = 5'd0;
        drive(1'b1, 5'd0, 32'hFFFFFFFF);
        check("t3_ready", 32'(bus.req_ready), 32'd1);
        step();
        drive(1'b0, 5'd0, 32'd0);
        check("t3_count", 32'(bus.count), 32'd0);
        check("t3_regwrite", 32'(bus.reg_write), 32'd0);
        check("t3_hit_reg0", 32'(bus.look_hit1), 32'd0);
        step();
        check("t3_regwrite_later", 32'(bus.reg_write), 32'd0);

        // Youngest-match bypass
        bus.hold = 1'b1;
        bus.look_reg1 = 5'd7;
        bus.look_reg2 = 5'd3;
        drive(1'b1, 5'd7, 32'h1);
        step();
        drive(1'b1, 5'd7, 32'h2);
        step();
        drive(1'b1, 5'd3, 32'h33);
        step();
        drive(1'b0, 5'd0, 32'd0);
        check("t4_hit1",  32'(bus.look_hit1), 32'd1);
        check("t4_data1", bus.look_data1, 32'h2);
        check("t4_hit2",  32'(bus.look_hit2), 32'd1);
        check("t4_data2", bus.look_data2, 32'h33);
        bus.look_reg2 = 5'd8;
        #1;
        check("t4_miss_hit2",  32'(bus.look_hit2), 32'd0);
        check("t4_miss_data2", bus.look_data2, 32'd0);
        bus.hold = 1'b0;
        #1;
        check("t4_w1_regno", 32'(bus.write_regno), 32'd7);
        check("t4_w1_data",  bus.write_data, 32'h1);
        step();
        check("t4_w2_regno", 32'(bus.write_regno), 32'd7);
        check("t4_w2_data",  bus.write_data, 32'h2);
        check("t4_hit_mid_drain", bus.look_data1, 32'h2);
        step();
        check("t4_w3_regno", 32'(bus.write_regno), 32'd3);
        check("t4_w3_data",  bus.write_data, 32'h33);
        step();
        check("t4_empty", 32'(bus.empty), 32'd1);

        // Steady push and pop every cycle across several pointer wraps
        drive(1'b1, 5'd10, 32'h100);
        step();
        for (int i = 1; i <= 10; i++) begin
            drive(1'b1, 5'((i % 31) + 1), 32'h100 + 32'(i));
            check("t5_count",    32'(bus.count), 32'd1);
            check("t5_ready",    32'(bus.req_ready), 32'd1);
            check("t5_regwrite", 32'(bus.reg_write), 32'd1);
            check("t5_wdata",    bus.write_data, 32'h100 + 32'(i - 1));
            step();
        end
        drive(1'b0, 5'd0, 32'd0);
        check("t5_last_wdata", bus.write_data, 32'h10A);
        check("t5_last_regno", 32'(bus.write_regno), 32'd11);
        step();
        check("t5_empty", 32'(bus.empty), 32'd1);

        // Asynchronous reset mid-operation
        bus.hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 5'(20 + i), 32'hA0 + 32'(i));
            step();
        end
        drive(1'b0, 5'd0, 32'd0);
        check("t6_count3", 32'(bus.count), 32'd3);
        bus.hold = 1'b0;
        #1;
        check("t6_regwrite_pre", 32'(bus.reg_write), 32'd1);
        rst = 1'b1;
        #1;
        check("t6_regwrite_rst", 32'(bus.reg_write), 32'd0);
        check("t6_count_rst",    32'(bus.count), 32'd0);
        check("t6_ready_rst",    32'(bus.req_ready), 32'd1);
        check("t6_empty_rst",    32'(bus.empty), 32'd1);
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t6_no_stale_write", 32'(bus.reg_write), 32'd0);
            check("t6_no_stale_count", 32'(bus.count), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
